// File: rtl/sram_load_verify_seq.sv
// Load / read-back-verify / run sequencer for one single-port SRAM.
// LOAD streams words into the SRAM. VERIFY compares SRAM contents against a
// golden stream and counts mismatches. RUN pulses seq_begin and then waits for
// seq_done, giving up after a timeout. Every output is registered.
module sram_load_verify_seq #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DEPTH       = 72,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned START_CYC   = 10,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q,
    output logic              seq_begin,
    input  logic              seq_done,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_any,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout,
    output logic              cmd_err
);

    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > START_CYC) ? TIMEOUT_CYC : START_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_VERIFY = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        VDRAIN,
        RUN_PULSE,
        RUN_WAIT
    } state_e;

    state_e            state_q, state_n;
    logic [LEN_W-1:0]  remain_q, remain_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;

    // Verify pipe: stage 1 lines up with the read strobe, stage 2 with mem_q.
    logic              vld1_q, vld1_n, vld2_q, vld2_n;
    logic [DATA_W-1:0] exp1_q, exp1_n, exp2_q, exp2_n;
    logic [ADDR_W-1:0] addr2_q, addr2_n;

    logic              in_ready_n, mem_cen_n, mem_wen_n, seq_begin_n;
    logic              busy_n, done_n, err_any_n, timeout_n, cmd_err_n;
    logic [ADDR_W-1:0] mem_addr_n, first_err_addr_n;
    logic [DATA_W-1:0] mem_d_n;
    logic [ERR_W-1:0]  err_cnt_n;

    logic hs;
    assign hs = in_valid & in_ready;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_n          = state_q;
        remain_n         = remain_q;
        ptr_n            = ptr_q;
        cnt_n            = cnt_q;
        vld1_n           = 1'b0;
        vld2_n           = vld1_q;
        exp1_n           = exp1_q;
        exp2_n           = exp1_q;
        addr2_n          = mem_addr;
        in_ready_n       = 1'b0;
        mem_cen_n        = 1'b1;
        mem_wen_n        = 1'b1;
        mem_addr_n       = mem_addr;
        mem_d_n          = mem_d;
        seq_begin_n      = 1'b0;
        busy_n           = busy;
        done_n           = 1'b0;
        err_cnt_n        = err_cnt;
        err_any_n        = err_any;
        first_err_addr_n = first_err_addr;
        timeout_n        = timeout;
        cmd_err_n        = cmd_err;

        // Compare stage runs whenever stage 2 holds an expected word.
        if (vld2_q && (mem_q != exp2_q)) begin
            if (err_cnt != '1) begin
                err_cnt_n = err_cnt + ERR_W'(1);
            end
            err_any_n = 1'b1;
            if (!err_any) begin
                first_err_addr_n = addr2_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    err_cnt_n        = '0;
                    err_any_n        = 1'b0;
                    first_err_addr_n = '0;
                    timeout_n        = 1'b0;
                    cmd_err_n        = 1'b0;
                    remain_n         = cmd_len;
                    ptr_n            = cmd_base;
                    cnt_n            = '0;
                    if ((cmd_mode == MODE_RSVD) ||
                        ((cmd_mode != MODE_RUN) && (cmd_len > LEN_W'(DEPTH)))) begin
                        cmd_err_n = 1'b1;
                        done_n    = 1'b1;
                    end else if (cmd_mode == MODE_RUN) begin
                        state_n     = RUN_PULSE;
                        seq_begin_n = 1'b1;
                        busy_n      = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n    = (cmd_mode == MODE_LOAD) ? LOAD : VERIFY;
                        busy_n     = 1'b1;
                        in_ready_n = 1'b1;
                    end
                end
            end

            LOAD: begin
                in_ready_n = in_ready;
                if (hs) begin
                    mem_cen_n  = 1'b0;
                    mem_wen_n  = 1'b0;
                    mem_addr_n = ptr_q;
                    mem_d_n    = in_data;
                    ptr_n      = ptr_q + ADDR_W'(1);
                    remain_n   = remain_q - LEN_W'(1);
                    in_ready_n = (remain_q != LEN_W'(1));
                end else if (remain_q == '0) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end

            VERIFY: begin
                in_ready_n = in_ready;
                if (hs) begin
                    mem_cen_n  = 1'b0;
                    mem_addr_n = ptr_q;
                    vld1_n     = 1'b1;
                    exp1_n     = in_data;
                    ptr_n      = ptr_q + ADDR_W'(1);
                    remain_n   = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        in_ready_n = 1'b0;
                        state_n    = VDRAIN;
                    end
                end
            end

            // Finish on the same edge that performs the last compare so that
            // done and the final err_cnt appear together.
            VDRAIN: begin
                if (vld2_q && !vld1_q) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end

            RUN_PULSE: begin
                seq_begin_n = 1'b1;
                cnt_n       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(START_CYC - 1)) begin
                    seq_begin_n = 1'b0;
                    cnt_n       = '0;
                    state_n     = RUN_WAIT;
                end
            end

            RUN_WAIT: begin
                if (seq_done) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves the SRAM deselected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            remain_q       <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            vld1_q         <= 1'b0;
            vld2_q         <= 1'b0;
            exp1_q         <= '0;
            exp2_q         <= '0;
            addr2_q        <= '0;
            in_ready       <= 1'b0;
            mem_cen        <= 1'b1;
            mem_wen        <= 1'b1;
            mem_addr       <= '0;
            mem_d          <= '0;
            seq_begin      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            err_any        <= 1'b0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            cmd_err        <= 1'b0;
        end else begin
            state_q        <= state_n;
            remain_q       <= remain_n;
            ptr_q          <= ptr_n;
            cnt_q          <= cnt_n;
            vld1_q         <= vld1_n;
            vld2_q         <= vld2_n;
            exp1_q         <= exp1_n;
            exp2_q         <= exp2_n;
            addr2_q        <= addr2_n;
            in_ready       <= in_ready_n;
            mem_cen        <= mem_cen_n;
            mem_wen        <= mem_wen_n;
            mem_addr       <= mem_addr_n;
            mem_d          <= mem_d_n;
            seq_begin      <= seq_begin_n;
            busy           <= busy_n;
            done           <= done_n;
            err_cnt        <= err_cnt_n;
            err_any        <= err_any_n;
            first_err_addr <= first_err_addr_n;
            timeout        <= timeout_n;
            cmd_err        <= cmd_err_n;
        end
    end

endmodule

// File: tb/tb_sram_load_verify_seq.sv
// Bench for sram_load_verify_seq: behavioural SRAM, random streams, and a
// reference memory image plus cycle rules derived from the command semantics.
`timescale 1ns/1ps
module tb_sram_load_verify_seq;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned DEPTH       = 72;
    localparam int unsigned ERR_W       = 16;
    localparam int unsigned START_CYC   = 10;
    localparam int unsigned TIMEOUT_CYC = 4096;
    localparam int unsigned MEM_WORDS   = 1 << ADDR_W;
    localparam int unsigned NEVER       = 32'hFFFF_FFFF;

    localparam logic [1:0] M_LOAD   = 2'b00;
    localparam logic [1:0] M_VERIFY = 2'b01;
    localparam logic [1:0] M_RUN    = 2'b10;
    localparam logic [1:0] M_RSVD   = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_start = 1'b0;
    logic [1:0]        cmd_mode = '0;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              mem_cen, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q = '0;
    logic              seq_begin;
    logic              seq_done = 1'b0;
    logic              busy, done;
    logic [ERR_W-1:0]  err_cnt;
    logic              err_any;
    logic [ADDR_W-1:0] first_err_addr;
    logic              timeout, cmd_err;

    sram_load_verify_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(ERR_W),
        .START_CYC(START_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q), .seq_begin(seq_begin), .seq_done(seq_done),
        .busy(busy), .done(done), .err_cnt(err_cnt), .err_any(err_any),
        .first_err_addr(first_err_addr), .timeout(timeout), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;

    logic [DATA_W-1:0] words   [MEM_WORDS];
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    logic [DATA_W-1:0] sram    [MEM_WORDS];

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int unsigned       wr_cyc_q  [$];
    int unsigned       exp_cyc_q [$];
    int unsigned       rd_cnt = 0;
    int unsigned       begin_cnt = 0;
    int unsigned       cen_cnt = 0;

    // Cycle counter: the value seen at #1 after an edge names that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_cen == 1'b0) begin
            if (mem_wen == 1'b0) sram[mem_addr] <= mem_d;
            else                 mem_q <= sram[mem_addr];
        end
    end

    // Bus monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_cen === 1'b0 && mem_wen === 1'b0) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_d);
            wr_cyc_q.push_back(cyc);
        end
        if (mem_cen === 1'b0 && mem_wen === 1'b1) rd_cnt = rd_cnt + 1;
        if (mem_cen === 1'b0) cen_cnt = cen_cnt + 1;
        if (seq_begin === 1'b1) begin_cnt = begin_cnt + 1;
    end

    task automatic issue(input logic [1:0] mode, input logic [ADDR_W-1:0] base,
                         input logic [ADDR_W:0] len);
        cmd_mode  = mode;
        cmd_base  = base;
        cmd_len   = len;
        cmd_start = 1'b1;
        acc_cyc   = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    // Issue a LOAD/VERIFY and stream words[0..len-1] with random in_valid gaps.
    task automatic stream(input logic [1:0] mode, input logic [ADDR_W-1:0] base,
                          input int unsigned len, input int unsigned gap_pct,
                          output int unsigned last_hs, output int unsigned done_cyc,
                          output bit to);
        int unsigned idx = 0;
        int unsigned budget = 0;
        logic hs;
        exp_cyc_q.delete();
        to = 1'b0;
        issue(mode, base, (ADDR_W+1)'(len));
        last_hs = cyc;
        while (done !== 1'b1) begin
            if (budget > 1000) begin
                to = 1'b1;
                break;
            end
            in_valid = (idx < len) && ($urandom_range(99) >= gap_pct);
            in_data  = words[idx];
            hs = in_valid && (in_ready === 1'b1);
            if (hs) begin
                last_hs = cyc;
                exp_cyc_q.push_back(cyc + 1);
            end
            @(posedge clk); #1;
            if (hs) idx++;
            budget++;
        end
        in_valid = 1'b0;
        done_cyc = cyc;
    endtask

    // Cycle (relative to accept) in which a RUN reports done, and whether by timeout.
    function automatic int unsigned run_expect(input int unsigned pulse_at,
                                               input int unsigned level_from,
                                               output bit exp_to);
        for (int unsigned c = START_CYC + 1; c <= START_CYC + TIMEOUT_CYC; c++) begin
            if (c == pulse_at || c >= level_from) begin
                exp_to = 1'b0;
                return c + 1;
            end
        end
        exp_to = 1'b1;
        return START_CYC + TIMEOUT_CYC + 1;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({mem_cen, mem_wen, in_ready, seq_begin, busy, done, err_any, timeout, cmd_err} !== 9'b110000000)
            $display("FAIL reset_ctrl got %b want 110000000",
                     {mem_cen, mem_wen, in_ready, seq_begin, busy, done, err_any, timeout, cmd_err});
        else n_pass++;
        n_total++;
        if ({err_cnt, first_err_addr, mem_addr} !== '0)
            $display("FAIL reset_data got err_cnt=%0d first=%0d addr=%0d want 0", err_cnt, first_err_addr, mem_addr);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_full();
        int unsigned last_hs, done_cyc, w0, bad;
        bit to;
        for (int i = 0; i < 72; i++) words[i] = $urandom;
        w0 = wr_addr_q.size();
        stream(M_LOAD, '0, 72, 0, last_hs, done_cyc, to);
        for (int i = 0; i < 72; i++) ref_mem[i] = words[i];
        n_total++;
        if (to) $display("FAIL load_full_timeout got no done want done"); else n_pass++;
        n_total++;
        if (done_cyc - acc_cyc != 74) $display("FAIL load_full_done_cycle got %0d want 74", done_cyc - acc_cyc);
        else n_pass++;
        n_total++;
        if ({busy, in_ready} !== 2'b00) $display("FAIL load_full_busy_at_done got %b want 00", {busy, in_ready});
        else n_pass++;
        n_total++;
        if (wr_addr_q.size() - w0 != 72) $display("FAIL load_full_strobes got %0d want 72", wr_addr_q.size() - w0);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 72 && w0 + i < wr_addr_q.size(); i++)
            if (wr_addr_q[w0+i] != ADDR_W'(i) || wr_data_q[w0+i] != words[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL load_full_addr_data got %0d bad strobes want 0", bad); else n_pass++;
        n_total++;
        if (wr_addr_q.size() >= w0 + 72 && wr_cyc_q[w0+71] - wr_cyc_q[w0] != 71)
            $display("FAIL load_full_consecutive got span %0d want 71", wr_cyc_q[w0+71] - wr_cyc_q[w0]);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 72; i++) if (sram[i] !== ref_mem[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL load_full_sram got %0d bad words want 0", bad); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL load_full_done_pulse got %b want 0", done); else n_pass++;
    endtask

    task automatic test_verify_errors();
        int unsigned last_hs, done_cyc, exp_err, rd0, w0;
        logic [ADDR_W-1:0] exp_first;
        bit to, seen;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 72; i++) words[i] = ref_mem[i];
            if (p == 0) begin
                words[5] = 32'hDEADBEEF;
            end else begin
                words[5]  = ~ref_mem[5];
                words[20] = ~ref_mem[20];
                words[60] = ~ref_mem[60];
            end
            exp_err = 0;
            seen = 1'b0;
            exp_first = '0;
            for (int i = 0; i < 72; i++) begin
                if (words[i] != ref_mem[i]) begin
                    exp_err++;
                    if (!seen) begin
                        seen = 1'b1;
                        exp_first = ADDR_W'(i);
                    end
                end
            end
            rd0 = rd_cnt;
            w0  = wr_addr_q.size();
            stream(M_VERIFY, '0, 72, (p == 0) ? 0 : 30, last_hs, done_cyc, to);
            n_total++;
            if (to) $display("FAIL verify%0d_timeout got no done want done", p); else n_pass++;
            n_total++;
            if (err_cnt !== ERR_W'(exp_err)) $display("FAIL verify%0d_err_cnt got %0d want %0d", p, err_cnt, exp_err);
            else n_pass++;
            n_total++;
            if (err_any !== (exp_err != 0)) $display("FAIL verify%0d_err_any got %b want %b", p, err_any, exp_err != 0);
            else n_pass++;
            n_total++;
            if (first_err_addr !== exp_first)
                $display("FAIL verify%0d_first_addr got %0d want %0d", p, first_err_addr, exp_first);
            else n_pass++;
            n_total++;
            if (done_cyc != last_hs + 3) $display("FAIL verify%0d_done_latency got %0d want %0d", p, done_cyc - last_hs, 3);
            else n_pass++;
            n_total++;
            if (rd_cnt - rd0 != 72 || wr_addr_q.size() != w0)
                $display("FAIL verify%0d_strobes got reads=%0d writes=%0d want 72/0", p, rd_cnt - rd0, wr_addr_q.size() - w0);
            else n_pass++;
        end
    endtask

    task automatic test_load_wrap_gaps();
        int unsigned last_hs, done_cyc, w0, bad;
        bit to;
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        w0 = wr_addr_q.size();
        stream(M_LOAD, ADDR_W'(120), 16, 40, last_hs, done_cyc, to);
        for (int i = 0; i < 16; i++) ref_mem[(120 + i) % MEM_WORDS] = words[i];
        n_total++;
        if (to) $display("FAIL wrap_timeout got no done want done"); else n_pass++;
        n_total++;
        if (wr_addr_q.size() - w0 != 16) $display("FAIL wrap_strobes got %0d want 16", wr_addr_q.size() - w0);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16 && w0 + i < wr_addr_q.size(); i++)
            if (wr_addr_q[w0+i] != ADDR_W'((120 + i) % MEM_WORDS) || wr_data_q[w0+i] != words[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL wrap_addr_data got %0d bad strobes want 0", bad); else n_pass++;
        bad = 0;
        for (int i = 0; i < 16 && w0 + i < wr_cyc_q.size() && i < exp_cyc_q.size(); i++)
            if (wr_cyc_q[w0+i] != exp_cyc_q[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL wrap_strobe_timing got %0d misplaced want 0", bad); else n_pass++;
        n_total++;
        if (done_cyc != last_hs + 2) $display("FAIL wrap_done_latency got %0d want 2", done_cyc - last_hs);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 72; i++) if (sram[i] !== ref_mem[i]) bad++;
        for (int i = 120; i < 128; i++) if (sram[i] !== ref_mem[i]) bad++;
        n_total++;
        if (bad != 0) $display("FAIL wrap_sram got %0d bad words want 0", bad); else n_pass++;
    endtask

    task automatic test_run();
        int unsigned pulse_at[3]   = '{START_CYC, 0, START_CYC + TIMEOUT_CYC};
        int unsigned level_from[3] = '{300, NEVER, NEVER};
        int unsigned exp_rel, b0, rel;
        bit exp_to;
        for (int k = 0; k < 3; k++) begin
            exp_rel = run_expect(pulse_at[k], level_from[k], exp_to);
            b0 = begin_cnt;
            issue(M_RUN, '0, '0);
            while (done !== 1'b1 && (cyc - acc_cyc) < START_CYC + TIMEOUT_CYC + 50) begin
                seq_done = ((cyc - acc_cyc) == pulse_at[k]) || ((cyc - acc_cyc) >= level_from[k]);
                @(posedge clk); #1;
            end
            seq_done = 1'b0;
            rel = cyc - acc_cyc;
            n_total++;
            if (done !== 1'b1 || rel != exp_rel)
                $display("FAIL run%0d_done_cycle got done=%b at %0d want done at %0d", k, done, rel, exp_rel);
            else n_pass++;
            n_total++;
            if (timeout !== exp_to) $display("FAIL run%0d_timeout got %b want %b", k, timeout, exp_to); else n_pass++;
            n_total++;
            if (begin_cnt - b0 != START_CYC)
                $display("FAIL run%0d_begin_len got %0d want %0d", k, begin_cnt - b0, START_CYC);
            else n_pass++;
            n_total++;
            if (busy !== 1'b0) $display("FAIL run%0d_busy got %b want 0", k, busy); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reject_and_busy();
        logic [1:0]      modes [4] = '{M_LOAD, M_VERIFY, M_RSVD, M_LOAD};
        logic [ADDR_W:0] lens  [4] = '{8'd73, 8'd73, 8'd5, 8'd0};
        int unsigned c0, b0, w0, budget, idx;
        logic hs;
        for (int k = 0; k < 4; k++) begin
            c0 = cen_cnt;
            issue(modes[k], ADDR_W'(3), lens[k]);
            n_total++;
            if ({done, cmd_err, busy} !== {1'b1, (k != 3), 1'b0})
                $display("FAIL reject%0d_response got done,cmd_err,busy=%b want %b", k, {done, cmd_err, busy}, {1'b1, (k != 3), 1'b0});
            else n_pass++;
            repeat (3) @(posedge clk);
            #1;
            n_total++;
            if ({done, cmd_err} !== {1'b0, (k != 3)} || cen_cnt != c0)
                $display("FAIL reject%0d_hold got done,cmd_err=%b cen_strobes=%0d want %b/0", k, {done, cmd_err}, cen_cnt - c0, {1'b0, (k != 3)});
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        b0 = begin_cnt;
        w0 = wr_addr_q.size();
        issue(M_LOAD, ADDR_W'(10), 8'd4);
        cmd_mode  = M_RUN;
        cmd_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmd_start = 1'b0;
        n_total++;
        if ({busy, in_ready, seq_begin} !== 3'b110)
            $display("FAIL busy_ignore_state got busy,in_ready,seq_begin=%b want 110", {busy, in_ready, seq_begin});
        else n_pass++;
        idx = 0;
        budget = 0;
        while (done !== 1'b1 && budget < 100) begin
            in_valid = (idx < 4);
            in_data  = words[idx];
            hs = in_valid && (in_ready === 1'b1);
            @(posedge clk); #1;
            if (hs) idx++;
            budget++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[10 + i] = words[i];
        n_total++;
        if (done !== 1'b1 || begin_cnt != b0 || wr_addr_q.size() - w0 != 4)
            $display("FAIL busy_ignore_result got done=%b begins=%0d writes=%0d want 1/0/4", done, begin_cnt - b0, wr_addr_q.size() - w0);
        else n_pass++;
        n_total++;
        if (wr_addr_q.size() >= w0 + 4 && (wr_addr_q[w0] != ADDR_W'(10) || wr_addr_q[w0+3] != ADDR_W'(13)))
            $display("FAIL busy_ignore_addr got %0d..%0d want 10..13", wr_addr_q[w0], wr_addr_q[w0+3]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_verify();
        int unsigned idx = 0;
        int unsigned budget = 0;
        int unsigned exp_err = 0;
        int unsigned c0, last_hs, done_cyc;
        logic hs;
        bit to;
        for (int i = 0; i < 72; i++) words[i] = ref_mem[i];
        words[2]  = ref_mem[2] ^ 32'h1;
        words[10] = ref_mem[10] ^ 32'h8000_0000;
        issue(M_VERIFY, '0, 8'd72);
        while (idx < 30 && budget < 200) begin
            in_valid = 1'b1;
            in_data  = words[idx];
            hs = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (hs) idx++;
            budget++;
        end
        // Words whose compare result is already visible three cycles after acceptance.
        for (int i = 0; i + 3 < 30; i++) if (words[i] != ref_mem[i]) exp_err++;
        n_total++;
        if (err_cnt !== ERR_W'(exp_err)) $display("FAIL mid_verify_err_cnt got %0d want %0d", err_cnt, exp_err);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if ({mem_cen, busy, in_ready, err_any} !== 4'b1000 || err_cnt !== '0)
            $display("FAIL reset_mid_outputs got cen,busy,rdy,any=%b err_cnt=%0d want 1000/0", {mem_cen, busy, in_ready, err_any}, err_cnt);
        else n_pass++;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        c0 = cen_cnt;
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (cen_cnt != c0 || busy !== 1'b0) $display("FAIL reset_mid_quiet got strobes=%0d busy=%b want 0/0", cen_cnt - c0, busy);
        else n_pass++;
        for (int i = 0; i < 72; i++) words[i] = ref_mem[i];
        stream(M_VERIFY, '0, 72, 20, last_hs, done_cyc, to);
        n_total++;
        if (to || err_cnt !== '0 || err_any !== 1'b0)
            $display("FAIL reset_mid_fresh got timeout=%b err_cnt=%0d err_any=%b want 0/0/0", to, err_cnt, err_any);
        else n_pass++;
        n_total++;
        if (done_cyc != last_hs + 3) $display("FAIL reset_mid_fresh_latency got %0d want 3", done_cyc - last_hs);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_verify_errors();
        test_load_wrap_gaps();
        test_run();
        test_reject_and_busy();
        test_reset_mid_verify();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
